// File: rtl/cu_pkg.sv
// Shared definitions for the cu_dut control unit: FSM states, opcode map,
// register-unit op codes, result selects and the strobe bundle type.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC1  = 3'd3,
        ST_EXEC2  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_COPY  = 4'h1;
    localparam logic [3:0] OP_LLS   = 4'h2;
    localparam logic [3:0] OP_LMS   = 4'h3;
    localparam logic [3:0] OP_CFR   = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_READ  = 4'h7;
    localparam logic [3:0] OP_WRITE = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] CS_AR_DR  = 4'd1;
    localparam logic [3:0] CS_AR_GR  = 4'd2;
    localparam logic [3:0] CS_DR_AR  = 4'd3;
    localparam logic [3:0] CS_DR_GR  = 4'd4;
    localparam logic [3:0] CS_GR_AR  = 4'd5;
    localparam logic [3:0] CS_GR_DR  = 4'd6;
    localparam logic [3:0] CS_LD_LS  = 4'd7;
    localparam logic [3:0] CS_LD_MS  = 4'd8;
    localparam logic [3:0] CS_CFR    = 4'd9;
    localparam logic [3:0] CS_ALU_DG = 4'd10;
    localparam logic [3:0] CS_ALU_GD = 4'd11;
    localparam logic [3:0] CS_RD_DR  = 4'd12;
    localparam logic [3:0] CS_RD_GR  = 4'd13;
    localparam logic [3:0] CS_WR_DR  = 4'd14;
    localparam logic [3:0] CS_WR_GR  = 4'd15;

    localparam logic [1:0] RS_NONE = 2'd0;
    localparam logic [1:0] RS_DR   = 2'd1;
    localparam logic [1:0] RS_GR   = 2'd2;

    typedef struct packed {
        logic       inc_pr;
        logic       load_ir;
        logic       set_pr;
        logic       mode;
        logic       rd;
        logic       wr;
        logic       rdm;
        logic [3:0] ctrl_sig;
        logic       copy_flag;
        logic [1:0] res_sel;
    } ctrl_t;

    function automatic logic op_is_illegal(input logic [7:0] ins);
        logic [3:0] op;
        logic [3:0] sub;
        logic       bad;
        op  = ins[7:4];
        sub = ins[3:0];
        case (op)
            OP_COPY:                          bad = (sub == 4'd0) || (sub > 4'd6);
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE:     bad = 1'b1;
            default:                          bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Opcodes that need a second execute cycle before returning to FETCH.
    function automatic logic op_two_phase(input logic [3:0] op);
        logic two;
        case (op)
            OP_LLS, OP_LMS, OP_ADD, OP_SUB, OP_READ, OP_WRITE: two = 1'b1;
            default:                                           two = 1'b0;
        endcase
        return two;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational strobe decoder: maps the current FSM state and the instruction
// byte held in the IR onto the datapath control bundle.
module cu_decode
    import cu_pkg::*;
(
    input  state_t     i_state,
    input  logic [7:0] i_instruction,
    output ctrl_t      o_ctrl
);

    logic [3:0] w_op;
    logic [3:0] w_sub;
    logic       w_bad;

    assign w_op  = i_instruction[7:4];
    assign w_sub = i_instruction[3:0];
    assign w_bad = op_is_illegal(i_instruction);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.rd      = 1'b1;
                o_ctrl.load_ir = 1'b1;
                o_ctrl.inc_pr  = 1'b1;
            end

            ST_EXEC1: begin
                case (w_op)
                    OP_COPY: begin
                        if (!w_bad) begin
                            o_ctrl.copy_flag = 1'b1;
                            o_ctrl.ctrl_sig  = w_sub;
                        end
                    end
                    OP_LLS, OP_LMS: begin
                        // operand byte follows the opcode, so fetch it via PR
                        o_ctrl.rd     = 1'b1;
                        o_ctrl.inc_pr = 1'b1;
                    end
                    OP_CFR: begin
                        o_ctrl.copy_flag = 1'b1;
                        o_ctrl.ctrl_sig  = CS_CFR;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl.copy_flag = 1'b1;
                        o_ctrl.ctrl_sig  = w_sub[0] ? CS_ALU_GD : CS_ALU_DG;
                        o_ctrl.mode      = (w_op == OP_SUB);
                    end
                    OP_READ: begin
                        o_ctrl.rd  = 1'b1;
                        o_ctrl.rdm = 1'b1;
                    end
                    OP_WRITE: begin
                        o_ctrl.copy_flag = 1'b1;
                        o_ctrl.ctrl_sig  = w_sub[0] ? CS_WR_GR : CS_WR_DR;
                    end
                    OP_JMP: begin
                        o_ctrl.set_pr = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            ST_EXEC2: begin
                case (w_op)
                    OP_LLS: begin
                        o_ctrl.copy_flag = 1'b1;
                        o_ctrl.ctrl_sig  = CS_LD_LS;
                    end
                    OP_LMS: begin
                        o_ctrl.copy_flag = 1'b1;
                        o_ctrl.ctrl_sig  = CS_LD_MS;
                    end
                    OP_ADD, OP_SUB: begin
                        // Mode held so the datapath's registered carry-in matches at capture
                        o_ctrl.res_sel = w_sub[1] ? RS_GR : RS_DR;
                        o_ctrl.mode    = (w_op == OP_SUB);
                    end
                    OP_READ: begin
                        o_ctrl.copy_flag = 1'b1;
                        o_ctrl.ctrl_sig  = w_sub[0] ? CS_RD_GR : CS_RD_DR;
                    end
                    OP_WRITE: begin
                        o_ctrl.wr  = 1'b1;
                        o_ctrl.rdm = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cu_dut.sv
// Multi-cycle control unit: fetch/decode/execute sequencer with run control,
// a sticky illegal-opcode flag and a retired-instruction counter.
module cu_dut
    import cu_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int ICNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        instruction,
    output logic              inc_PR,
    output logic              load_IR,
    output logic              set_PR,
    output logic              Mode,
    output logic              RD,
    output logic              WR,
    output logic              RDM,
    output logic [3:0]        ctrl_sig,
    output logic              copy_flag,
    output logic [1:0]        res_sel,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [ICNT_W-1:0] icount
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_illegal;
    logic [ICNT_W-1:0]  r_icount;
    logic               w_set_illegal;
    logic               w_retire;
    logic               w_bad;
    logic [OPC_W-1:0]   w_op;
    ctrl_t              w_ctrl;

    assign w_op  = instruction[7 -: OPC_W];
    assign w_bad = op_is_illegal(instruction);

    cu_decode u_decode (
        .i_state       (r_state),
        .i_instruction (instruction),
        .o_ctrl        (w_ctrl)
    );

    always_comb begin
        w_state_next  = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_bad) begin
                    w_set_illegal = 1'b1;
                    w_state_next  = ST_HALT;
                end else if (w_op == OP_NOP) begin
                    w_state_next = ST_FETCH;
                end else if (w_op == OP_HALT) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                w_state_next = op_two_phase(w_op) ? ST_EXEC2 : ST_FETCH;
            end
            ST_EXEC2: begin
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Only returns to FETCH from an instruction count; the initial IDLE->FETCH does not.
    assign w_retire = (w_state_next == ST_FETCH) &&
                      ((r_state == ST_DECODE) || (r_state == ST_EXEC1) || (r_state == ST_EXEC2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_illegal <= 1'b0;
            r_icount  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_icount <= r_icount + 1'b1;
            end
        end
    end

    assign inc_PR    = w_ctrl.inc_pr;
    assign load_IR   = w_ctrl.load_ir;
    assign set_PR    = w_ctrl.set_pr;
    assign Mode      = w_ctrl.mode;
    assign RD        = w_ctrl.rd;
    assign WR        = w_ctrl.wr;
    assign RDM       = w_ctrl.rdm;
    assign ctrl_sig  = w_ctrl.ctrl_sig;
    assign copy_flag = w_ctrl.copy_flag;
    assign res_sel   = w_ctrl.res_sel;

    assign busy    = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                     (r_state == ST_EXEC1) || (r_state == ST_EXEC2);
    assign halted  = (r_state == ST_HALT);
    assign illegal = r_illegal;
    assign icount  = r_icount;

endmodule

// File: doc/cu_dut.md
Name: cu_dut

Overview:
Multi-cycle control unit for the 8-bit scalar processor, sitting directly upstream of du_dut.
- Sequences fetch/decode/execute.
- Consumes the instruction byte held in du_dut's instruction register.
- Drives every du_dut control strobe: PR increment/load, IR load, bus RD/WR, address select, register-unit op code, result select, ALU mode.
- Adds run control (start/halt), a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
OPC_W, 4, opcode field width (instruction[7:4]); sub-field is instruction[3:0].
ICNT_W, 8, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  leave IDLE and begin fetching; sampled only in IDLE.
instruction  input  8  current IR contents from du_dut.
inc_PR  output  1  PR <= PR+1.
load_IR  output  1  IR <= data bus.
set_PR  output  1  PR <= AR (jump).
Mode  output  1  ALU subtract when 1; du_dut registers it into cin each clock.
RD  output  1  memory read strobe.
WR  output  1  memory write strobe.
RDM  output  1  1 = address from AR, 0 = address from PR.
ctrl_sig  output  4  register-unit op code (1..15), valid only with copy_flag.
copy_flag  output  1  execute ctrl_sig this cycle.
res_sel  output  2  1 = DR<=ALU result, 2 = GR<=ALU result, 0 = none.
busy  output  1  high in FETCH/DECODE/EXEC1/EXEC2.
halted  output  1  high in HALT.
illegal  output  1  sticky; set on an undefined opcode or COPY sub-code.
icount  output  ICNT_W  retired-instruction count.

Behaviour:
- State register encoding: IDLE, FETCH, DECODE, EXEC1, EXEC2, HALT.
- Reset (rst=0, any time, including mid-instruction): state=IDLE, illegal=0, icount=0, all strobes 0, ctrl_sig=0, res_sel=0.
- Control outputs are combinational from state + instruction. Any strobe not listed for a state is 0.
- IDLE: start=1 -> FETCH.
- FETCH: RD=1, RDM=0, load_IR=1, inc_PR=1 -> DECODE. IR is valid from DECODE onward.
- DECODE: no strobes.
  - NOP -> FETCH.
  - HALT -> HALT.
  - Illegal -> set illegal, go to HALT.
  - Otherwise -> EXEC1.
- Opcodes (op=instruction[7:4], s=instruction[3:0]); EXEC1 / EXEC2 actions:
  - 0x0 NOP: none.
  - 0x1 COPY: s in 1..6. EXEC1: copy_flag, ctrl_sig=s. s=0 or s>6 is illegal.
  - 0x2 LLS: EXEC1: RD, RDM=0, inc_PR (operand byte). EXEC2: copy_flag, ctrl_sig=7.
  - 0x3 LMS: as LLS, with ctrl_sig=8 in EXEC2.
  - 0x4 CFR: EXEC1: copy_flag, ctrl_sig=9.
  - 0x5 ADD / 0x6 SUB:
    - EXEC1: copy_flag, ctrl_sig = s[0]?11:10.
    - EXEC2: res_sel = s[1]?2:1.
    - Mode = (op==6) in BOTH EXEC1 and EXEC2, so registered cin is correct when the result is captured.
  - 0x7 READ: EXEC1: RD, RDM=1. EXEC2: copy_flag, ctrl_sig = s[0]?13:12.
  - 0x8 WRITE: EXEC1: copy_flag, ctrl_sig = s[0]?15:14. EXEC2: WR, RDM=1.
  - 0x9 JMP: EXEC1: set_PR.
  - 0xF HALT.
  - 0xA-0xE: illegal.
- EXEC1 -> EXEC2 for two-phase opcodes, otherwise -> FETCH. EXEC2 -> FETCH.
- icount increments by 1 on every transition into FETCH from DECODE, EXEC1 or EXEC2. Wraps at 2^ICNT_W-1 -> 0. The IDLE->FETCH transition does not count.
- Latencies (clocks per instruction, including FETCH):
  - NOP: 2.
  - COPY, CFR, JMP: 3.
  - LLS, LMS, ADD, SUB, READ, WRITE: 4.
- HALT: sticky until reset. start is ignored. halted=1, busy=0.
- RD and WR are never both 1. copy_flag and res_sel!=0 are never both active.

Decomposition:
- Shared package cu_pkg:
  - State enum.
  - Opcode constants (OP_NOP..OP_HALT).
  - ctrl_sig constants (CS_AR_DR=1 .. CS_WR_GR=15).
  - res_sel constants (RS_NONE, RS_DR, RS_GR).
- One sub-module is natural: cu_decode, a purely combinational map from (state, instruction) to the strobe bundle. The FSM, illegal flag and icount stay in cu_dut.

Test Plan:
1. Reset mid-EXEC1 of ADD (rst low for 1 cycle) -> all strobes 0, state IDLE, icount=0, illegal=0; start then yields FETCH with RD=1, load_IR=1, inc_PR=1.
2. instruction=0x52 (ADD, DR op order, dest GR) -> EXEC1: copy_flag=1, ctrl_sig=10, Mode=0; EXEC2: res_sel=2; back in FETCH 4 clocks after the previous FETCH; icount+1.
3. instruction=0x61 (SUB) -> Mode=1 in both EXEC1 and EXEC2; ctrl_sig=11; res_sel=1.
4. READ 0x71 then WRITE 0x80 -> READ: EXEC1 RD=1, RDM=1; EXEC2 ctrl_sig=13. WRITE: EXEC1 ctrl_sig=14; EXEC2 WR=1, RDM=1, RD=0.
5. instruction=0x90 -> set_PR=1 for exactly 1 cycle, inc_PR=0 in that cycle. Then LLS 0x20 -> EXEC1 RD=1, RDM=0, inc_PR=1; EXEC2 ctrl_sig=7.
6. COPY 0x17, and separately 0xB0 -> illegal=1, halted=1, busy=0; start pulses ignored; icount frozen. Then 0xFF-count wrap: 256 NOPs from icount=0 -> icount returns to 0x00.
